// File: rtl/crc_stream_feeder_if.sv
// rtl/crc_stream_feeder_if.sv - word stream, CRC register bus and result port of the CRC feeder
// res_err exists only when CRC_FEEDER_TIMEOUT_EN is defined.
interface crc_stream_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;

    logic        Sel;
    logic        RW;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;

    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
`ifdef CRC_FEEDER_TIMEOUT_EN
    logic        res_err;
`endif

    modport master (
        input  in_valid, in_data, in_last, data_rd, res_ready,
        output in_ready, Sel, RW, addr, data_wr, res_valid, res_data
`ifdef CRC_FEEDER_TIMEOUT_EN
        , output res_err
`endif
    );

    modport slave (
        output in_valid, in_data, in_last, data_rd, res_ready,
        input  in_ready, Sel, RW, addr, data_wr, res_valid, res_data
`ifdef CRC_FEEDER_TIMEOUT_EN
        , input res_err
`endif
    );
endinterface

// File: rtl/crc_stream_feeder.sv
// rtl/crc_stream_feeder.sv - buffers packet words and programs the CRC peripheral per packet
// Optional DATA-stall timeout (adds TIMEOUT_CYCLES and res_err): define CRC_FEEDER_TIMEOUT_EN.
module crc_stream_feeder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] CRC_BASE   = 32'h4003_2000
`ifdef CRC_FEEDER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         cfg_ctrl,
    input  logic [31:0]         cfg_poly,
    input  logic [31:0]         cfg_seed,
    output logic                busy,
    output logic [15:0]         word_cnt,
    crc_stream_feeder_if.master ifc
);
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    localparam logic [31:0] ADDR_DATA = CRC_BASE;
    localparam logic [31:0] ADDR_POLY = CRC_BASE + 32'd4;
    localparam logic [31:0] ADDR_CTRL = CRC_BASE + 32'd8;
    localparam logic [31:0] WAS_BIT   = 32'h0200_0000;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CTRL_S = 3'd1;
    localparam logic [2:0] S_POLY   = 3'd2;
    localparam logic [2:0] S_SEED   = 3'd3;
    localparam logic [2:0] S_CTRL_D = 3'd4;
    localparam logic [2:0] S_DATA   = 3'd5;
    localparam logic [2:0] S_RD     = 3'd6;
    localparam logic [2:0] S_RES    = 3'd7;

    logic [32:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [32:0]   w_head;

    logic [2:0]    r_state;
    logic          r_sel;
    logic          r_rw;
    logic [31:0]   r_addr;
    logic [31:0]   r_data_wr;
    logic          r_res_valid;
    logic [31:0]   r_res_data;
    logic [15:0]   r_word_cnt;
    logic          r_wlast;
    logic [31:0]   r_cfg_ctrl;
    logic [31:0]   r_cfg_poly;
    logic [31:0]   r_cfg_seed;
    logic          w_data_slot;

    assign w_full        = (r_count == DEPTH);
    assign w_empty       = (r_count == '0);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_push        = ifc.in_valid && !w_full && !w_drop;
    assign ifc.in_ready  = !w_full;

    // Bus outputs are registered, so the pop is decided one edge ahead of the write it feeds.
    assign w_data_slot = (r_state == S_CTRL_D) || ((r_state == S_DATA) && !r_wlast);
    assign w_pop       = w_data_slot && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {ifc.in_last, ifc.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef CRC_FEEDER_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_res_err;
    logic        r_discard;
    logic        w_timeout;

    assign w_timeout   = (r_state == S_DATA) && !r_wlast && w_empty &&
                         (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
    // Words arriving on the timeout edge belong to the abandoned packet as well.
    assign w_drop      = r_discard || w_timeout;
    assign ifc.res_err = r_res_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_discard <= 1'b0;
        end else if (w_drop && ifc.in_valid && !w_full && ifc.in_last) begin
            r_discard <= 1'b0;
        end else if (w_timeout) begin
            r_discard <= 1'b1;
        end
    end
`else
    assign w_drop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_data_wr   <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_word_cnt  <= '0;
            r_wlast     <= 1'b0;
            r_cfg_ctrl  <= '0;
            r_cfg_poly  <= '0;
            r_cfg_seed  <= '0;
`ifdef CRC_FEEDER_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_res_err   <= 1'b0;
`endif
        end else begin
            r_sel <= 1'b0;
            r_rw  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state    <= S_CTRL_S;
                        r_cfg_ctrl <= cfg_ctrl;
                        r_cfg_poly <= cfg_poly;
                        r_cfg_seed <= cfg_seed;
                        r_sel      <= 1'b1;
                        r_rw       <= 1'b1;
                        r_addr     <= ADDR_CTRL;
                        r_data_wr  <= cfg_ctrl | WAS_BIT;
                    end
                end
                S_CTRL_S: begin
                    r_state   <= S_POLY;
                    r_sel     <= 1'b1;
                    r_rw      <= 1'b1;
                    r_addr    <= ADDR_POLY;
                    r_data_wr <= r_cfg_poly;
                end
                S_POLY: begin
                    r_state   <= S_SEED;
                    r_sel     <= 1'b1;
                    r_rw      <= 1'b1;
                    r_addr    <= ADDR_DATA;
                    r_data_wr <= r_cfg_seed;
                end
                S_SEED: begin
                    r_state    <= S_CTRL_D;
                    r_sel      <= 1'b1;
                    r_rw       <= 1'b1;
                    r_addr     <= ADDR_CTRL;
                    r_data_wr  <= r_cfg_ctrl & ~WAS_BIT;
                    r_word_cnt <= '0;
`ifdef CRC_FEEDER_TIMEOUT_EN
                    r_to_cnt   <= '0;
`endif
                end
                S_CTRL_D, S_DATA: begin
                    if ((r_state == S_DATA) && r_wlast) begin
                        r_state   <= S_RD;
                        r_sel     <= 1'b1;
                        r_rw      <= 1'b0;
                        r_addr    <= ADDR_DATA;
                        r_data_wr <= '0;
                        r_wlast   <= 1'b0;
                    end else begin
                        r_state <= S_DATA;
                        if (w_pop) begin
                            r_sel     <= 1'b1;
                            r_rw      <= 1'b1;
                            r_addr    <= ADDR_DATA;
                            r_data_wr <= w_head[31:0];
                            r_wlast   <= w_head[32];
                            if (r_word_cnt != 16'hFFFF) begin
                                r_word_cnt <= r_word_cnt + 16'd1;
                            end
`ifdef CRC_FEEDER_TIMEOUT_EN
                            r_to_cnt <= '0;
`endif
                        end else begin
                            r_wlast <= 1'b0;
`ifdef CRC_FEEDER_TIMEOUT_EN
                            if (w_timeout) begin
                                r_state     <= S_RES;
                                r_res_valid <= 1'b1;
                                r_res_data  <= '0;
                                r_res_err   <= 1'b1;
                                r_to_cnt    <= '0;
                            end else if (r_state == S_DATA) begin
                                r_to_cnt <= r_to_cnt + 32'd1;
                            end
`endif
                        end
                    end
                end
                S_RD: begin
                    r_state     <= S_RES;
                    r_res_valid <= 1'b1;
                    r_res_data  <= ifc.data_rd;
                end
                S_RES: begin
                    if (ifc.res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
`ifdef CRC_FEEDER_TIMEOUT_EN
                        r_res_err   <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ifc.Sel       = r_sel;
    assign ifc.RW        = r_rw;
    assign ifc.addr      = r_addr;
    assign ifc.data_wr   = r_data_wr;
    assign ifc.res_valid = r_res_valid;
    assign ifc.res_data  = r_res_data;
    assign busy          = (r_state != S_IDLE);
    assign word_cnt      = r_word_cnt;
endmodule

// File: tb/tb_crc_stream_feeder.sv
// tb/tb_crc_stream_feeder.sv - scoreboard bench for crc_stream_feeder with a behavioural CRC peripheral
module tb_crc_stream_feeder;
    localparam logic [31:0] BASE = 32'h4003_2000;
    localparam logic [31:0] WAS  = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cfg_ctrl = '0;
    logic [31:0] cfg_poly = '0;
    logic [31:0] cfg_seed = '0;
    logic        busy;
    logic [15:0] word_cnt;
    int          tests_run = 0;
    int          tests_failed = 0;

    logic [64:0] bus_q [$];
    logic [48:0] res_q [$];
    logic [31:0] pkt [$];
    logic [64:0] bus_e;
    logic [48:0] res_e;

    crc_stream_feeder_if ifc ();

    crc_stream_feeder #(
        .FIFO_DEPTH(8),
        .CRC_BASE(BASE)
`ifdef CRC_FEEDER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_ctrl(cfg_ctrl),
        .cfg_poly(cfg_poly),
        .cfg_seed(cfg_seed),
        .busy(busy),
        .word_cnt(word_cnt),
        .ifc(ifc)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] w,
                                             input logic [31:0] p, input logic wide);
        logic [31:0] r;
        r = wide ? c : {16'h0, c[15:0]};
        for (int i = 31; i >= 0; i--) begin
            if (wide) r = {r[30:0], 1'b0} ^ ((r[31] ^ w[i]) ? p : 32'h0);
            else      r = {16'h0, r[14:0], 1'b0} ^ ((r[15] ^ w[i]) ? {16'h0, p[15:0]} : 32'h0);
        end
        return r;
    endfunction

    // Behavioural CRC peripheral: WAS=1 loads the seed, TCRC selects 32/16-bit width.
    logic [31:0] m_ctrl = '0;
    logic [31:0] m_poly = '0;
    logic [31:0] m_crc  = '0;
    always @(posedge clk) begin
        if (ifc.Sel && ifc.RW) begin
            if (ifc.addr == BASE + 32'd8)      m_ctrl <= ifc.data_wr;
            else if (ifc.addr == BASE + 32'd4) m_poly <= ifc.data_wr;
            else if (ifc.addr == BASE)
                m_crc <= m_ctrl[25] ? ifc.data_wr : crc_step(m_crc, ifc.data_wr, m_poly, m_ctrl[24]);
        end
    end
    assign ifc.data_rd = m_ctrl[24] ? m_crc : {16'h0, m_crc[15:0]};

    always @(negedge clk) begin
        if (rst && ifc.Sel) begin
            if (bus_q.size() == 0) begin
                check("bus_unexpected", 64'({ifc.RW, ifc.addr}), 64'd0);
            end else begin
                bus_e = bus_q.pop_front();
                check("bus_rw_addr", 64'({ifc.RW, ifc.addr}), 64'(bus_e[64:32]));
                if (bus_e[64]) check("bus_wdata", 64'(ifc.data_wr), 64'(bus_e[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && ifc.res_valid && ifc.res_ready) begin
            if (res_q.size() == 0) begin
                check("res_unexpected", 64'(ifc.res_data), 64'hDEAD_0000_0000_0000);
            end else begin
                res_e = res_q.pop_front();
                check("res_data", 64'(ifc.res_data), 64'(res_e[31:0]));
                check("res_word_cnt", 64'(word_cnt), 64'(res_e[47:32]));
`ifdef CRC_FEEDER_TIMEOUT_EN
                check("res_err", 64'(ifc.res_err), 64'(res_e[48]));
`endif
            end
        end
    end

    task automatic exp_w(input logic [31:0] a, input logic [31:0] d);
        bus_q.push_back({1'b1, a, d});
    endtask

    task automatic push_preamble();
        exp_w(BASE + 32'd8, cfg_ctrl | WAS);
        exp_w(BASE + 32'd4, cfg_poly);
        exp_w(BASE, cfg_seed);
        exp_w(BASE + 32'd8, cfg_ctrl & ~WAS);
    endtask

    task automatic expect_pkt();
        logic [31:0] crc;
        push_preamble();
        crc = cfg_seed;
        foreach (pkt[i]) begin
            exp_w(BASE, pkt[i]);
            crc = crc_step(crc, pkt[i], cfg_poly, cfg_ctrl[24]);
        end
        bus_q.push_back({1'b0, BASE, 32'h0});
        if (!cfg_ctrl[24]) crc = {16'h0, crc[15:0]};
        res_q.push_back({1'b0, 16'(pkt.size()), crc});
    endtask

    task automatic push_word(input logic [31:0] d, input logic l);
        int n = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_last  = l;
        while (!ifc.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("push_ready_wait", 64'(ifc.in_ready), 64'd1);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic drive_pkt();
        foreach (pkt[i]) push_word(pkt[i], i == pkt.size() - 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || res_q.size() != 0 || ifc.in_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 64'(busy), 64'd0);
        check("bus_q_drained", 64'(bus_q.size()), 64'd0);
        check("res_q_drained", 64'(res_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, 64'(ifc.Sel), 64'd0);
        check({tag, "_rw"}, 64'(ifc.RW), 64'd0);
        check({tag, "_addr"}, 64'(ifc.addr), 64'd0);
        check({tag, "_data_wr"}, 64'(ifc.data_wr), 64'd0);
        check({tag, "_res_valid"}, 64'(ifc.res_valid), 64'd0);
        check({tag, "_res_data"}, 64'(ifc.res_data), 64'd0);
        check({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_in_ready"}, 64'(ifc.in_ready), 64'd1);
`ifdef CRC_FEEDER_TIMEOUT_EN
        check({tag, "_res_err"}, 64'(ifc.res_err), 64'd0);
`endif
    endtask

    initial begin
        int n;
        logic [31:0] exp_a;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_last   = 1'b0;
        ifc.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Single-word packet, 32-bit mode, with latency measurement.
        cfg_ctrl = 32'h0100_0000;
        cfg_poly = 32'h04C1_1DB7;
        cfg_seed = 32'hFFFF_FFFF;
        pkt = '{32'h0000_1234};
        expect_pkt();
        drive_pkt();
        n = 0;
        while (word_cnt != 16'd1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("lat_first_write", 64'(n), 64'd5);
        n = 0;
        while (!ifc.res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("lat_res_valid", 64'(n), 64'd2);
        wait_idle();

        // 16-bit mode, two words.
        cfg_ctrl = 32'h0;
        cfg_poly = 32'h0000_1021;
        cfg_seed = 32'h0000_FFFF;
        pkt = '{32'h3132_3334, 32'h3536_3738};
        expect_pkt();
        drive_pkt();
        wait_idle();

        // Result back-pressure while the next 9-word packet fills the FIFO.
        cfg_ctrl = 32'h0100_0000;
        cfg_poly = 32'h04C1_1DB7;
        cfg_seed = 32'h1234_5678;
        ifc.res_ready = 1'b0;
        pkt = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
        expect_pkt();
        drive_pkt();
        n = 0;
        while (!ifc.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_res_rise", 64'(ifc.res_valid), 64'd1);
        exp_a = res_q[0][31:0];
        pkt = '{};
        for (int k = 0; k < 9; k++) pkt.push_back(32'hB000_0000 + 32'(k * 32'h0101_0101));
        expect_pkt();
        fork
            drive_pkt();
        join_none
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_valid", 64'(ifc.res_valid), 64'd1);
            check("hold_data", 64'(ifc.res_data), 64'(exp_a));
            check("hold_sel", 64'(ifc.Sel), 64'd0);
        end
        check("fifo_full", 64'(ifc.in_ready), 64'd0);
        @(posedge clk); #1;
        ifc.res_ready = 1'b1;
        n = 0;
        while (word_cnt != 16'd1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_first", 64'(word_cnt), 64'd1);
        for (int k = 2; k <= 9; k++) begin
            @(posedge clk); #1;
            check("b2b_cnt", 64'(word_cnt), 64'(k));
        end
        wait_idle();

        // Asynchronous reset in DATA after three words, then a fresh packet.
        cfg_seed = 32'h0BAD_F00D;
        pkt = '{32'hC000_0001, 32'hC000_0002, 32'hC000_0003};
        push_preamble();
        foreach (pkt[i]) exp_w(BASE, pkt[i]);
        foreach (pkt[i]) push_word(pkt[i], 1'b0);
        n = 0;
        while (word_cnt != 16'd3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_reset_cnt", 64'(word_cnt), 64'd3);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        bus_q.delete();
        res_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        pkt = '{};
        for (int k = 0; k < 4; k++) pkt.push_back($urandom);
        expect_pkt();
        drive_pkt();
        wait_idle();

`ifdef CRC_FEEDER_TIMEOUT_EN
        // Input stall mid-packet: error result, trailing words dropped, next packet clean.
        pkt = '{32'hD000_0001, 32'hD000_0002};
        push_preamble();
        foreach (pkt[i]) exp_w(BASE, pkt[i]);
        res_q.push_back({1'b1, 16'd2, 32'h0});
        foreach (pkt[i]) push_word(pkt[i], 1'b0);
        n = 0;
        while (!ifc.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_res_valid", 64'(ifc.res_valid), 64'd1);
        check("to_res_err", 64'(ifc.res_err), 64'd1);
        wait_idle();
        push_word(32'hD000_0003, 1'b0);
        push_word(32'hD000_0004, 1'b1);
        repeat (10) @(negedge clk);
        check("drop_idle", 64'(busy), 64'd0);
        pkt = '{32'hE000_0001, 32'hE000_0002, 32'hE000_0003};
        expect_pkt();
        drive_pkt();
        wait_idle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/crc_stream_feeder.md
Name: crc_stream_feeder

Overview:
- Upstream master for the CRC peripheral at 0x4003_2000.
- Accepts 32-bit packet words on a valid/ready stream and buffers them in a small FIFO.
- Per packet, programs the CRC through its single-cycle Sel/RW register bus: control, polynomial, seed, then every data word.
- Reads back the checksum and presents it on a result valid/ready port. Frees software from per-word register pokes.

Parameters:
- FIFO_DEPTH, 8, input word FIFO entries; power of two, 2..64.
- CRC_BASE, 32'h4003_2000, CRC data register address; POLY = CRC_BASE+4, CTRL = CRC_BASE+8.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  FIFO not full
- in_data  in  32  packet word
- in_last  in  1  marks final word of packet
- cfg_ctrl  in  32  CRC control value (TOT/TOTR/FXOR/TCRC); bit 25 (WAS) ignored
- cfg_poly  in  32  polynomial
- cfg_seed  in  32  seed
- Sel  out  1  CRC bus select
- RW  out  1  1 = write, 0 = read
- addr  out  32  CRC bus address
- data_wr  out  32  CRC write data
- data_rd  in  32  CRC read data (combinational from CRC)
- res_valid  out  1  checksum valid
- res_data  out  32  checksum
- res_ready  in  1  result accepted
- busy  out  1  state != IDLE
- word_cnt  out  16  data words issued in current/last packet

Behaviour:
Reset (rst=0, async):
- FIFO empty; state IDLE.
- Sel=0, RW=0, addr=0, data_wr=0, res_valid=0, res_data=0, word_cnt=0.
- All bus outputs are registered.

FIFO:
- Stores {in_last, in_data}; push when in_valid && in_ready.
- in_ready = !full; combinational from count only.
- Pop only in DATA state when a bus write is issued.
- Simultaneous push and pop when full is not allowed (in_ready=0). Push and pop in the same cycle when non-full: count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Config sampling:
- cfg_* latched on the IDLE->CTRL_S transition and held for the whole packet.

Bus rule:
- Every access is one cycle with Sel=1.
- Writes take effect at the CRC on the edge that ends the cycle.
- Sel=0 in every cycle not listed below.

FSM (one state = one bus cycle unless stated):
- IDLE: Sel=0. Go to CTRL_S when FIFO non-empty.
- CTRL_S: write CTRL <- cfg_ctrl | 1<<25 (WAS=1, seed-load mode).
- POLY: write POLY <- cfg_poly.
- SEED: write DATA <- cfg_seed.
- CTRL_D: write CTRL <- cfg_ctrl & ~(1<<25). Clear word_cnt.
- DATA:
  - If FIFO non-empty: pop, write DATA <- word, word_cnt += 1 (saturates at 16'hFFFF). Go to RD if the popped word's last=1, else stay.
  - If FIFO empty: Sel=0 and wait; no timeout unless the optional feature is enabled.
- RD: Sel=1, RW=0, addr=CRC_BASE. Register data_rd into res_data at the end of the cycle.
- RES: res_valid=1, res_data stable. On res_ready go to IDLE with res_valid=0 next cycle.

Timing and boundaries:
- Latency: first word present in FIFO -> first data write = 5 cycles. last data write -> res_valid = 2 cycles.
- Single-word packet (in_last on first word) is legal: exactly one data write.
- New-packet words may be pushed while in RD/RES; they are not popped until the next CTRL_S.
- Reset mid-packet: FIFO flushed, bus idle immediately. The CRC is reprogrammed fully on the next packet, so no stale state matters.

Optional Feature:
- Macro CRC_FEEDER_TIMEOUT_EN.
- When defined:
  - Parameter TIMEOUT_CYCLES (default 256) and output res_err (1 bit, reset 0) are added.
  - In DATA, a counter increments each cycle the FIFO is empty and clears on a pop.
  - When the counter reaches TIMEOUT_CYCLES: go to RES without RD, res_data=0, res_err=1.
  - Later words up to and including the next in_last are discarded on arrival.
  - res_err clears when the result is accepted.
- When undefined: DATA waits indefinitely; no res_err port.

Test Plan:
- Reset then one packet of 1 word 0x0000_1234, cfg_ctrl=0x0100_0000, cfg_poly=0x04C1_1DB7, cfg_seed=0xFFFF_FFFF. Required bus sequence: W 0x4003_2008=0x0300_0000; W 0x4003_2004=0x04C1_1DB7; W 0x4003_2000=0xFFFF_FFFF; W 0x4003_2008=0x0100_0000; W 0x4003_2000=0x0000_1234; R 0x4003_2000. res_data equals the model CRC; word_cnt=1.
- 16-bit mode: cfg_ctrl=0, cfg_poly=0x1021, seed=0xFFFF, words 0x3132_3334 then 0x3536_3738 (last). res_data[31:16]=0 and matches the model; word_cnt=2.
- Burst of 9 words with FIFO_DEPTH=8 while the FSM is in CTRL_S. in_ready drops when full. No word is lost or reordered; data writes are back-to-back once DATA is reached.
- Hold res_ready=0 for 10 cycles. res_valid and res_data remain stable; no bus activity (Sel=0); second packet words accepted into the FIFO; second packet starts only after the handshake.
- Assert rst=0 during DATA after 3 words. Outputs return to reset values asynchronously. A following fresh packet produces the full 4-write preamble and the correct result.
- With CRC_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=4: stall the input mid-packet. res_valid and res_err rise; res_data=0; trailing words through in_last are dropped; the next packet completes normally with res_err=0.
